// File: rtl/mul_share_ctrl.sv
// Round-robin controller sharing one multi-cycle multiplier core among NUM_REQ
// requesters, with a watchdog that turns a missing done into an error response.
module mul_share_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [2*DATA_WIDTH-1:0]       rsp_data,
  output logic                          rsp_err,
  output logic                          mul_start,
  output logic [DATA_WIDTH-1:0]         mul_a,
  output logic [DATA_WIDTH-1:0]         mul_b,
  input  logic                          mul_done,
  input  logic [2*DATA_WIDTH-1:0]       mul_product,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt;
  logic [ID_W-1:0]  scan_idx;
  logic             gnt_found;
  logic [ID_W-1:0]  next_ptr;
  logic [CNT_W-1:0] wd_cnt;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt       = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found) req_ready[gnt] = 1'b1;
  end

  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      rsp_valid <= '0;
      mul_start <= 1'b0;
      busy      <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      wd_cnt    <= '0;
    end else begin
      mul_start <= 1'b0;
      unique case (state)
        // gnt_found in IDLE implies req_ready[gnt] is high, so this is the handshake.
        IDLE: begin
          if (gnt_found) begin
            mul_a     <= req_a[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
            mul_b     <= req_b[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
            grant_id  <= gnt;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        // Done is checked before the watchdog so a same-cycle done still wins.
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (mul_done) begin
            rsp_data            <= mul_product;
            rsp_err             <= 1'b0;
            rsp_valid[grant_id] <= 1'b1;
            state               <= RESP;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_data            <= '0;
            rsp_err             <= 1'b1;
            rsp_valid[grant_id] <= 1'b1;
            state               <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            rr_ptr    <= next_ptr;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: a behavioural arbiter/latency model predicts
// each response; a monitor process compares the DUT against the queued predictions.
`timescale 1ns/1ps
module tb_mul_share_ctrl;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 64;

  typedef struct {
    int          id;
    logic [63:0] data;
    bit          err;
    longint      due;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0]        req_a, req_b;
  logic [2*DW-1:0]        rsp_data, mul_product;
  logic                   rsp_err, mul_start, mul_done, busy;
  logic [DW-1:0]          mul_a, mul_b;
  logic [$clog2(N)-1:0]   grant_id;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  exp_t        exp_q[$];
  int          lat_q[$];
  logic [DW-1:0] pa[N];
  logic [DW-1:0] pb[N];
  int          lat_of[N];
  int          model_rr = 0;
  bit          in_flight = 0;
  bit          exp_start = 0;
  bit          rsp_seen = 0;
  logic [N-1:0] hs_mask = '0;
  int          epoch = 0;

  int          mg;
  bit          merr;
  exp_t        me;

  mul_share_ctrl #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic submit(int i, logic [DW-1:0] a, logic [DW-1:0] b, int lat);
    pa[i] = a;
    pb[i] = b;
    lat_of[i] = lat;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((req_valid != 0 || exp_q.size() != 0 || in_flight) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle pending=%b queued=%0d budget=%0d", req_valid, exp_q.size(), budget);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_grant_id", grant_id, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    hs_mask = '0;
    exp_q.delete();
    lat_q.delete();
    in_flight = 0;
    exp_start = 0;
    rsp_seen = 0;
    model_rr = 0;
    epoch++;
    tick();
    rst = 1'b0;
    check_reset_vals();
  endtask

  // Accepted requesters drop valid just after the accepting edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      req_valid = req_valid & ~hs_mask;
      hs_mask = '0;
    end
  end

  // Multiplier core: done L cycles after the start cycle, latency 0 means never.
  initial begin : core
    logic [DW-1:0] ca, cb;
    int clat, cep;
    mul_done = 1'b0;
    mul_product = '0;
    forever begin
      @(negedge clk);
      if (mul_start === 1'b1 && rst === 1'b0) begin
        ca = mul_a;
        cb = mul_b;
        cep = epoch;
        clat = (lat_q.size() == 0) ? 1 : lat_q.pop_front();
        if (clat > 0) begin
          repeat (clat) @(posedge clk);
          #1;
          if (cep == epoch) begin
            chk("mul_a_hold", mul_a, ca);
            chk("mul_b_hold", mul_b, cb);
          end
          mul_done = 1'b1;
          mul_product = 64'(ca) * 64'(cb);
          @(posedge clk);
          #1;
          mul_done = 1'b0;
          mul_product = '0;
        end
      end
    end
  end

  // Monitor: reference arbiter/latency model plus scoreboard comparison.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        chk("busy", busy, in_flight);
        chk("mul_start", mul_start, exp_start);
        exp_start = 0;
        if (in_flight) begin
          chk("req_ready_busy", req_ready, 0);
        end else if (req_valid != 0) begin
          mg = -1;
          for (int k = 0; k < N; k++)
            if (mg < 0 && req_valid[(model_rr + k) % N]) mg = (model_rr + k) % N;
          chk("grant", req_ready, 64'(1) << mg);
          hs_mask = req_valid & req_ready;
          merr = (lat_of[mg] == 0) || (lat_of[mg] > TO);
          me.id = mg;
          me.data = merr ? 64'd0 : 64'(pa[mg]) * 64'(pb[mg]);
          me.err = merr;
          me.due = cyc + 2 + (merr ? TO : lat_of[mg]);
          exp_q.push_back(me);
          lat_q.push_back(lat_of[mg]);
          in_flight = 1;
          exp_start = 1;
        end else begin
          chk("req_ready_idle", req_ready, 0);
        end
        if (rsp_valid != 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected rsp_valid=%b required=0", rsp_valid);
          end else begin
            me = exp_q[0];
            chk("rsp_valid", rsp_valid, 64'(1) << me.id);
            chk("rsp_data", rsp_data, me.data);
            chk("rsp_err", rsp_err, me.err);
            chk("grant_id", grant_id, me.id);
            if (!rsp_seen) begin
              chk("rsp_latency", cyc, me.due);
              rsp_seen = 1;
            end
            if (rsp_ready[me.id]) begin
              void'(exp_q.pop_front());
              rsp_seen = 0;
              in_flight = 0;
              model_rr = (me.id + 1) % N;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    logic [DW-1:0] ra, rb;
    int rl, n;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals();

    // Single request
    submit(0, 32'h3, 32'h5, 3);
    wait_idle(50);

    // All requesters at once from a fresh arbiter, then resubmit
    do_reset();
    submit(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    submit(1, 32'h0001_0000, 32'h0001_0000, 2);
    submit(2, 32'h8000_0000, 32'h2, 2);
    submit(3, 32'h0, 32'h1234_5678, 2);
    wait_idle(100);
    for (int i = 0; i < N; i++) submit(i, $urandom, $urandom, 2);
    wait_idle(100);

    // Requester 2 stalls its response; spurious done arrives while in RESP
    rsp_ready = 4'b1011;
    submit(2, 32'h1234_5678, 32'h9ABC_DEF0, 2);
    n = 0;
    while (rsp_valid[2] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("stall_rsp_seen", rsp_valid[2], 1);
    submit(0, 32'd7, 32'd9, 1);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        mul_done = 1'b1;
        mul_product = 64'hDEAD_BEEF_0BAD_F00D;
      end else if (k == 5) begin
        mul_done = 1'b0;
        mul_product = '0;
      end
      tick();
    end
    rsp_ready = '1;
    wait_idle(50);

    // Spurious done while idle
    tick();
    mul_done = 1'b1;
    mul_product = 64'h1111_2222_3333_4444;
    tick();
    mul_done = 1'b0;
    mul_product = '0;
    tick();
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_rsp_data", rsp_data, 64'd63);

    // Watchdog timeout, then a normal job; done exactly at the timeout boundary
    submit(1, 32'hAAAA_AAAA, 32'h5555_5555, 0);
    wait_idle(200);
    submit(1, 32'h10, 32'h20, 5);
    wait_idle(50);
    submit(3, 32'hCAFE_0001, 32'h0000_0100, TO);
    wait_idle(200);
    submit(0, 32'hFFFF_0000, 32'h0000_FFFF, TO - 1);
    wait_idle(200);

    // Reset during WAIT discards the job and restarts the round-robin at 0
    submit(2, 32'd11, 32'd13, 4);
    wait_idle(50);
    submit(2, 32'd21, 32'd23, 20);
    repeat (6) tick();
    do_reset();
    repeat (25) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    submit(3, 32'd5, 32'd6, 2);
    submit(0, 32'd7, 32'd8, 2);
    wait_idle(100);

    // Randomized traffic with random response back-pressure
    for (int c = 0; c < 600; c++) begin
      rsp_ready = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          ra = $urandom;
          rb = $urandom;
          case ($urandom_range(0, 7))
            0: ra = '1;
            1: rb = '0;
            default: ;
          endcase
          rl = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 8));
          submit(i, ra, rb, rl);
        end
      end
      tick();
    end
    rsp_ready = '1;
    wait_idle(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Round-robin controller that shares one multi-cycle multiplier core among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and sequences the core with a start/done handshake.
- Returns each product to the requester that issued it.
- Provides a watchdog that returns an error response if the core never signals done.
- Sits between the AXI4-Lite register front-ends and the multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, operand width; the product is 2*DATA_WIDTH.
- TIMEOUT, 64, maximum number of WAIT cycles before an error response (>=2).

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester operand accept.
- req_a  in  NUM_REQ*DATA_WIDTH  operand A; requester i occupies slice [i*DW +: DW].
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing as req_a.
- rsp_valid  out  NUM_REQ  per-requester result valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  2*DATA_WIDTH  product; shared bus, meaningful only where rsp_valid is set.
- rsp_err  out  1  timeout flag for the current response.
- mul_start  out  1  one-cycle start pulse to the core.
- mul_a, mul_b  out  DATA_WIDTH  operands to the core; held stable from ISSUE through WAIT.
- mul_done  in  1  core completion pulse.
- mul_product  in  2*DATA_WIDTH  core result; valid in the cycle mul_done is high.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the requester currently being served.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_id=0.
- Reset values (cont.): all req_ready, rsp_valid, mul_start and busy low; rsp_err=0; rsp_data, mul_a and mul_b all 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - g = first index with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[g] is driven combinationally high only in IDLE and only for g; all other req_ready bits stay 0.
  - On req_valid[g] && req_ready[g]: latch req_a/req_b slice g into mul_a/mul_b, set grant_id=g, go to ISSUE.
  - With no req_valid set, stay in IDLE.
- ISSUE: mul_start=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - mul_done=1: capture mul_product into rsp_data, set rsp_err=0, go to RESP.
  - Counter reaches TIMEOUT-1 without done: set rsp_data=0 and rsp_err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid[grant_id]=1; rsp_data and rsp_err are held stable.
  - On rsp_ready[grant_id]: clear rsp_valid, set rr_ptr=(grant_id+1) mod NUM_REQ, go to IDLE.
  - rsp_ready on any other index is ignored.
- mul_done is sampled only in WAIT. A done pulse in IDLE, ISSUE or RESP (stale or spurious) is ignored and does not change state.
- Minimum latency, with accept at edge 0:
  - mul_start at cycle 1.
  - Earliest mul_done at cycle 2.
  - rsp_valid at cycle 3.
  - Back to IDLE at cycle 4 if rsp_ready is already high.
- The next request can be accepted in the cycle after returning to IDLE. There is no back-to-back overlap; only one job is in flight.
- req_valid changes on non-granted requesters during a job have no effect. Those requesters wait; there is no starvation because rr_ptr rotates after every completion.
- ARESET asserted in any state: next edge returns to the reset values above. Any in-flight result is discarded; no rsp_valid is issued for it.
- Arithmetic: the controller does no arithmetic on data. Products pass through at full 2*DATA_WIDTH width, unsigned, unmodified.

Test Plan:
- Single request: requester 0 sends A=0x00000003, B=0x00000005; core done after 3 cycles -> rsp_valid[0] with rsp_data=0x0F and rsp_err=0; mul_start high exactly 1 cycle.
- All 4 requesters valid at the same time, core latency 2 -> grant order 0,1,2,3, then 0 again on resubmit; each requester receives its own product (e.g. A=0xFFFFFFFF, B=0xFFFFFFFF gives 0xFFFFFFFE00000001).
- Requester 2 holds rsp_ready low for 10 cycles -> rsp_valid[2] and rsp_data stay stable; no new req_ready during that time; mul_start stays low.
- Core never asserts done, TIMEOUT=64 -> after 64 WAIT cycles rsp_valid=1 with rsp_err=1 and rsp_data=0; the next job then completes normally with rsp_err=0.
- ARESET pulsed for 1 cycle during WAIT, then mul_done arrives -> stays in IDLE; no rsp_valid; rr_ptr=0, so requester 0 wins the next grant.
- Spurious mul_done in IDLE and in RESP -> no state change and rsp_data unchanged.
